// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - valid/ready pipeline stage register with flush and optional skid entry (PIPE_SKID_EN)
module pipe_stage_reg #(
    parameter int DATA_W = 68,
    parameter int CTRL_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl
);

    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q,  data_d;
    logic [CTRL_W-1:0] ctrl_q,  ctrl_d;
    logic              accept;
    logic              deliver;

    assign accept    = in_valid & in_ready;
    assign deliver   = valid_q & out_ready;
    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_ctrl  = ctrl_q;

`ifdef PIPE_SKID_EN
    logic              skid_valid_q, skid_valid_d;
    logic [DATA_W-1:0] skid_data_q,  skid_data_d;
    logic [CTRL_W-1:0] skid_ctrl_q,  skid_ctrl_d;

    // Ready depends only on skid occupancy, so out_ready never reaches in_ready combinationally.
    assign in_ready = ~skid_valid_q;

    always_comb begin
        valid_d      = valid_q;
        data_d       = data_q;
        ctrl_d       = ctrl_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        skid_ctrl_d  = skid_ctrl_q;
        if (flush) begin
            valid_d      = 1'b0;
            ctrl_d       = '0;
            skid_valid_d = 1'b0;
            skid_ctrl_d  = '0;
        end else if (deliver && skid_valid_q) begin
            valid_d      = 1'b1;
            data_d       = skid_data_q;
            ctrl_d       = skid_ctrl_q;
            skid_valid_d = 1'b0;
            skid_ctrl_d  = '0;
        end else if (accept && (!valid_q || deliver)) begin
            valid_d = 1'b1;
            data_d  = in_data;
            ctrl_d  = in_ctrl;
        end else if (accept) begin
            skid_valid_d = 1'b1;
            skid_data_d  = in_data;
            skid_ctrl_d  = in_ctrl;
        end else if (deliver) begin
            valid_d = 1'b0;
            ctrl_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q      <= 1'b0;
            data_q       <= '0;
            ctrl_q       <= '0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            skid_ctrl_q  <= '0;
        end else begin
            valid_q      <= valid_d;
            data_q       <= data_d;
            ctrl_q       <= ctrl_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            skid_ctrl_q  <= skid_ctrl_d;
        end
    end
`else
    assign in_ready = ~valid_q | out_ready;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        ctrl_d  = ctrl_q;
        // A beat accepted during flush is dropped; the payload register keeps its old value.
        if (flush) begin
            valid_d = 1'b0;
            ctrl_d  = '0;
        end else if (accept) begin
            valid_d = 1'b1;
            data_d  = in_data;
            ctrl_d  = in_ctrl;
        end else if (deliver) begin
            valid_d = 1'b0;
            ctrl_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            ctrl_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            ctrl_q  <= ctrl_d;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - randomized and directed bench for pipe_stage_reg against a queue model
module tb_pipe_stage_reg;
    localparam int DW = 68;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic [DW-1:0] in_data, out_data;
    logic [CW-1:0] in_ctrl, out_ctrl;

    always #5 clk = ~clk;

    pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ctrl(out_ctrl)
    );

    typedef struct packed {
        logic [DW-1:0] d;
        logic [CW-1:0] c;
    } beat_t;

    beat_t         q[$];
    logic [DW-1:0] m_last = '0;
    bit            m_known = 1'b0;
    int            checks = 0;
    int            failures = 0;

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0b expected=%0b", name, act, exp);
        end
    endtask

    task automatic chkd(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic chkc(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic m_ready();
`ifdef PIPE_SKID_EN
        return q.size() < 2;
`else
        return (q.size() == 0) || out_ready;
`endif
    endfunction

    task automatic m_compare();
        chk1("model_in_ready", in_ready, m_ready());
        chk1("model_out_valid", out_valid, q.size() != 0);
        if (q.size() != 0) begin
            chkd("model_out_data", out_data, q[0].d);
            chkc("model_out_ctrl", out_ctrl, q[0].c);
        end else begin
            chkd("model_out_data_hold", out_data, m_last);
            chkc("model_out_ctrl_bubble", out_ctrl, '0);
        end
    endtask

    task automatic m_update();
        logic  acc;
        logic  del;
        beat_t b;
        if (rst) begin
            q.delete();
            m_last = '0;
        end else begin
            acc = in_valid && m_ready();
            del = (q.size() != 0) && out_ready;
            if (flush) begin
                q.delete();
            end else begin
                if (del) void'(q.pop_front());
                if (acc) begin
                    b.d = in_data;
                    b.c = in_ctrl;
                    q.push_back(b);
                end
            end
            if (q.size() != 0) m_last = q[0].d;
        end
    endtask

    // Compare at the falling edge, advance the model at the rising edge, return 1 time unit later.
    task automatic step();
        @(negedge clk);
        if (m_known) m_compare();
        @(posedge clk);
        m_update();
        if (rst) m_known = 1'b1;
        #1;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
        in_data = DW'(32'h77); in_ctrl = 4'hF;
        step(); step();
        chk1("rst_valid", out_valid, 1'b0);
        chkc("rst_ctrl", out_ctrl, 4'h0);
        chkd("rst_data", out_data, '0);
        chk1("rst_in_ready", in_ready, 1'b1);
        rst = 1'b0; in_valid = 1'b0;

        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1; in_data = DW'(i); in_ctrl = CW'(i);
            step();
            chk1("stream_valid", out_valid, 1'b1);
            chkd("stream_data", out_data, DW'(i));
        end
        in_valid = 1'b0;
        step();
        chk1("stream_drain_valid", out_valid, 1'b0);
        chkc("stream_drain_ctrl", out_ctrl, 4'h0);
        chkd("stream_drain_data_hold", out_data, DW'(8));

        out_ready = 1'b0; in_valid = 1'b1; in_data = DW'(32'hA5); in_ctrl = 4'b0011;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk1("stall_valid", out_valid, 1'b1);
            chkd("stall_data", out_data, DW'(32'hA5));
            chkc("stall_ctrl", out_ctrl, 4'b0011);
        end
        out_ready = 1'b1;
        step();
        chk1("stall_release_once", out_valid, 1'b0);

        out_ready = 1'b0; in_valid = 1'b1; in_data = DW'(32'h0B); in_ctrl = 4'b1111;
        step();
        flush = 1'b1; in_data = DW'(32'h0C); in_ctrl = 4'b0101;
        step();
        flush = 1'b0; in_valid = 1'b0;
        chk1("flush_valid", out_valid, 1'b0);
        chkc("flush_ctrl", out_ctrl, 4'h0);
        out_ready = 1'b1;
        step(); step();
        chk1("flush_no_ghost", out_valid, 1'b0);

`ifdef PIPE_SKID_EN
        out_ready = 1'b0; in_valid = 1'b1; in_data = DW'(32'h10); in_ctrl = 4'h1;
        step();
        chk1("skid_ready_after_first", in_ready, 1'b1);
        in_data = DW'(32'h11); in_ctrl = 4'h2;
        step();
        chk1("skid_ready_after_second", in_ready, 1'b0);
        in_valid = 1'b0;
        chkd("skid_first_out", out_data, DW'(32'h10));
        out_ready = 1'b1;
        step();
        chk1("skid_second_valid", out_valid, 1'b1);
        chkd("skid_second_out", out_data, DW'(32'h11));
        chk1("skid_ready_restored", in_ready, 1'b1);
        step();
        chk1("skid_drained", out_valid, 1'b0);
`endif

        out_ready = 1'b0; in_valid = 1'b1; in_data = DW'(32'h20); in_ctrl = 4'h3;
        step();
        in_data = DW'(32'h21); in_ctrl = 4'h4;
        step();
        in_valid = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0; out_ready = 1'b1;
        chk1("midrst_valid", out_valid, 1'b0);
        chkd("midrst_data", out_data, '0);
        step(); step();
        chk1("midrst_no_beat", out_valid, 1'b0);
        chk1("midrst_in_ready", in_ready, 1'b1);

        for (int n = 0; n < 3000; n++) begin
            rst       = ($urandom_range(99) == 0);
            flush     = ($urandom_range(15) == 0);
            in_valid  = ($urandom_range(3) != 0);
            out_ready = ($urandom_range(2) != 0);
            in_data   = {4'($urandom), 32'($urandom), 32'($urandom)};
            in_ctrl   = 4'($urandom);
            step();
        end
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
